// File: rtl/noc_apb_pkg.sv
// Shared types and widths for the NOC-to-APB master ports.
// States and response codes are visible to checkers through the top's debug port.
package noc_apb_pkg;
   localparam int APB_AW = 32;
   localparam int APB_DW = 32;
   localparam int APB_SW = APB_DW / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef enum logic [1:0] {
      OK      = 2'b00,
      SLVERR  = 2'b01,
      TIMEOUT = 2'b10
   } apb_rsp_e;
endpackage

// File: rtl/noc_apb_timeout_cnt.sv
// Access-phase watchdog: clear/enable counter that saturates instead of wrapping.
// expired flags the last permitted wait cycle; TIMEOUT_CYCLES = 0 never expires.
module noc_apb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LAST);
endmodule

// File: rtl/noc_apb_s4_master.sv
// APB4 master for NOC slave 4: one request in, one APB transfer, one response out.
// Every output comes straight from a flop; control flops are loaded from the next state.
module noc_apb_s4_master
   import noc_apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 16
) (
   input  logic              ACLK,
   input  logic              ASW_RESET,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WRITE,
   input  logic [APB_AW-1:0] REQ_ADDR,
   input  logic [APB_DW-1:0] REQ_WDATA,
   input  logic [APB_SW-1:0] REQ_STRB,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [APB_DW-1:0] RSP_RDATA,
   output logic [1:0]        RSP_ERR,
   output logic              S4_PSEL,
   output logic              S4_PENABLE,
   output logic              S4_PWRITE,
   output logic [APB_AW-1:0] S4_PADDR,
   output logic [APB_DW-1:0] S4_PDATA,
   output logic [APB_SW-1:0] S4_PSTRB,
   input  logic [APB_DW-1:0] S4_PRDATA,
   input  logic              S4_PREADY,
   input  logic              S4_PSLVERR,
   output apb_state_e        dbg_state
);
   // Handshakes: a transfer happens on the edge where valid && ready are both high;
   // the sender holds valid and payload stable until then, ready never depends on valid.

   apb_state_e        state_q, state_d;
   logic              req_ready_q, rsp_valid_q, psel_q, penable_q, pwrite_q;
   logic [APB_AW-1:0] paddr_q;
   logic [APB_DW-1:0] pdata_q, rsp_rdata_q;
   logic [APB_SW-1:0] pstrb_q;
   apb_rsp_e          rsp_err_q;
   logic              req_fire, capture, expired;

   noc_apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk     (ACLK),
      .rst     (ASW_RESET),
      .clr     (state_q == SETUP),
      .en      ((state_q == ACCESS) && !S4_PREADY),
      .expired (expired)
   );

   assign req_fire = REQ_VALID && req_ready_q;
   assign capture  = (state_q == ACCESS) && (state_d == RESP);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_fire) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         // PREADY is checked first so a ready slave beats the watchdog in the same cycle
         ACCESS:  if (S4_PREADY || expired) state_d = RESP;
         RESP:    if (RSP_READY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ASW_RESET) begin
      if (ASW_RESET) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= (state_d == IDLE);
         psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
         penable_q   <= (state_d == ACCESS);
         rsp_valid_q <= (state_d == RESP);
      end
   end

   always_ff @(posedge ACLK or posedge ASW_RESET) begin
      if (ASW_RESET) begin
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pdata_q  <= '0;
         pstrb_q  <= '0;
      end else if (req_fire) begin
         pwrite_q <= REQ_WRITE;
         paddr_q  <= REQ_ADDR;
         pdata_q  <= REQ_WDATA;
         pstrb_q  <= REQ_WRITE ? REQ_STRB : '0;
      end
   end

   // Without PREADY at the exit edge the only way out of ACCESS was the watchdog.
   always_ff @(posedge ACLK or posedge ASW_RESET) begin
      if (ASW_RESET) begin
         rsp_err_q   <= OK;
         rsp_rdata_q <= '0;
      end else if (capture) begin
         if (S4_PREADY) begin
            rsp_err_q   <= S4_PSLVERR ? SLVERR : OK;
            rsp_rdata_q <= (!pwrite_q && !S4_PSLVERR) ? S4_PRDATA : '0;
         end else begin
            rsp_err_q   <= TIMEOUT;
            rsp_rdata_q <= '0;
         end
      end
   end

   assign REQ_READY  = req_ready_q;
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_RDATA  = rsp_rdata_q;
   assign RSP_ERR    = rsp_err_q;
   assign S4_PSEL    = psel_q;
   assign S4_PENABLE = penable_q;
   assign S4_PWRITE  = pwrite_q;
   assign S4_PADDR   = paddr_q;
   assign S4_PDATA   = pdata_q;
   assign S4_PSTRB   = pstrb_q;
   assign dbg_state  = state_q;
endmodule
